// File: rtl/puf_pkg.sv
// puf_pkg
//  Shared definitions for the PUF majority-vote sequencer.
//  - puf_state_e : sequencer FSM encoding (IDLE, LAUNCH, WAIT, RESOLVE)
//  - DEF_RESP_W / DEF_CHAL_W : default response and challenge widths
//  - cnt_w()     : width of a per-bit vote counter able to hold 0..votes
package puf_pkg;

    localparam int DEF_RESP_W = 256;
    localparam int DEF_CHAL_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LAUNCH  = 2'd1,
        ST_WAIT    = 2'd2,
        ST_RESOLVE = 2'd3
    } puf_state_e;

    // A counter that sees at most 'votes' increments never wraps with this width.
    function automatic int cnt_w(input int votes);
        return (votes < 1) ? 1 : $clog2(votes + 1);
    endfunction

endpackage

// File: rtl/popcount.sv
// popcount
//  Combinational population count built as a balanced binary adder tree.
//  The input is zero-extended to the next power of two so every level pairs up
//  cleanly; each tree node is only as wide as the final count, which always
//  suffices because no subtree can sum to more than W.
//  Ports:
//    bits_in  in   W               vector to count
//    count    out  $clog2(W+1)     number of ones in bits_in
module popcount #(
    parameter int W = 8
) (
    input  logic [W-1:0]           bits_in,
    output logic [$clog2(W+1)-1:0] count
);

    localparam int OW = $clog2(W + 1);
    localparam int LV = (W > 1) ? $clog2(W) : 0;
    localparam int N  = 1 << LV;

    logic [N-1:0] padded;
    assign padded = N'(bits_in);

    // Heap-ordered tree: node 0 is the root, leaves occupy N-1 .. 2N-2.
    always_comb begin
        logic [OW-1:0] node [2*N-1];
        for (int i = 0; i < N; i++) begin
            node[N-1+i] = OW'(padded[i]);
        end
        for (int j = N - 2; j >= 0; j--) begin
            node[j] = node[2*j+1] + node[2*j+2];
        end
        count = node[0];
    end

endmodule

// File: rtl/puf_vote_seq.sv
// puf_vote_seq
//  Majority-vote stabiliser in front of the RO PUF core. One accepted start
//  issues the same challenge VOTES times, counts ones per response bit, then
//  publishes the majority response, a mask of bits that disagreed and the number
//  of such bits.
//  Ports:
//    clk, reset_n                  clock, asynchronous active-low reset
//    start, challenge_in           request pulse (IDLE only) and its challenge
//    puf_start, puf_challenge      launch pulse and held challenge to the PUF core
//    puf_done, puf_response        PUF completion pulse and its response
//    busy                          high in every state except IDLE
//    resp_valid                    one-cycle pulse when results are updated
//    response, unstable_mask       majority response / disagreeing bits
//    unstable_cnt                  popcount of unstable_mask
//    err_timeout                   one-cycle pulse: PUF silent for TMO_CYC cycles
module puf_vote_seq
    import puf_pkg::*;
#(
    parameter int RESP_W  = DEF_RESP_W,
    parameter int CHAL_W  = DEF_CHAL_W,
    parameter int VOTES   = 5,
    parameter int TMO_CYC = 4096
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        start,
    input  logic [CHAL_W-1:0]           challenge_in,
    output logic                        puf_start,
    output logic [CHAL_W-1:0]           puf_challenge,
    input  logic                        puf_done,
    input  logic [RESP_W-1:0]           puf_response,
    output logic                        busy,
    output logic                        resp_valid,
    output logic [RESP_W-1:0]           response,
    output logic [RESP_W-1:0]           unstable_mask,
    output logic [$clog2(RESP_W+1)-1:0] unstable_cnt,
    output logic                        err_timeout
);

    localparam int CNT_W = cnt_w(VOTES);
    localparam int UC_W  = $clog2(RESP_W + 1);
    localparam int RUN_W = (VOTES > 1) ? $clog2(VOTES) : 1;
    localparam int TMR_W = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;

    puf_state_e        state_q, state_d;
    logic [CHAL_W-1:0] chal_q, chal_d;
    logic [RUN_W-1:0]  run_q, run_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;
    logic              done_blk_q, done_blk_d;
    logic              valid_q, valid_d;
    logic [RESP_W-1:0] resp_q, resp_d;
    logic [RESP_W-1:0] mask_q, mask_d;
    logic [UC_W-1:0]   ucnt_q, ucnt_d;
    logic [CNT_W-1:0]  cnt_q [RESP_W];
    logic [CNT_W-1:0]  cnt_d [RESP_W];

    logic              start_acc;
    logic              done_acc;
    logic              tmr_last;
    logic              err_now;
    logic [RESP_W-1:0] majority_bits;
    logic [RESP_W-1:0] unstable_bits;
    logic [UC_W-1:0]   pop_cnt;

    assign start_acc = (state_q == ST_IDLE) && start;
    // A done level that stays high is consumed once; it must drop before another
    // completion is accepted, so a long pulse cannot leak into the next run.
    assign done_acc  = (state_q == ST_WAIT) && puf_done && !done_blk_q;
    assign tmr_last  = (tmr_q == TMR_W'(TMO_CYC - 1));

    // ------------------------------------------------------------------
    // Per-bit vote evaluation of the accumulated counters
    // ------------------------------------------------------------------
    genvar gi;
    for (gi = 0; gi < RESP_W; gi++) begin : g_vote
        assign majority_bits[gi] = (cnt_q[gi] > CNT_W'(VOTES / 2));
        assign unstable_bits[gi] = (cnt_q[gi] != '0) && (cnt_q[gi] != CNT_W'(VOTES));
    end

    popcount #(.W(RESP_W)) u_popcount (
        .bits_in (unstable_bits),
        .count   (pop_cnt)
    );

    // ------------------------------------------------------------------
    // FSM next state and datapath control
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        chal_d     = chal_q;
        run_d      = run_q;
        tmr_d      = tmr_q;
        valid_d    = 1'b0;
        err_now    = 1'b0;
        resp_d     = resp_q;
        mask_d     = mask_q;
        ucnt_d     = ucnt_q;
        done_blk_d = puf_done ? (done_blk_q | done_acc) : 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    chal_d  = challenge_in;
                    run_d   = '0;
                    state_d = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                tmr_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                tmr_d = tmr_q + TMR_W'(1);
                // A completion in the final timer cycle still counts.
                if (done_acc) begin
                    if (run_q == RUN_W'(VOTES - 1)) begin
                        state_d = ST_RESOLVE;
                    end else begin
                        run_d   = run_q + RUN_W'(1);
                        state_d = ST_LAUNCH;
                    end
                end else if (tmr_last) begin
                    err_now = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_RESOLVE: begin
                resp_d  = majority_bits;
                mask_d  = unstable_bits;
                ucnt_d  = pop_cnt;
                valid_d = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        for (int i = 0; i < RESP_W; i++) begin
            cnt_d[i] = cnt_q[i];
            if (start_acc) begin
                cnt_d[i] = '0;
            end else if (done_acc) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(puf_response[i]);
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            chal_q     <= '0;
            run_q      <= '0;
            tmr_q      <= '0;
            done_blk_q <= 1'b0;
            valid_q    <= 1'b0;
            resp_q     <= '0;
            mask_q     <= '0;
            ucnt_q     <= '0;
        end else begin
            state_q    <= state_d;
            chal_q     <= chal_d;
            run_q      <= run_d;
            tmr_q      <= tmr_d;
            done_blk_q <= done_blk_d;
            valid_q    <= valid_d;
            resp_q     <= resp_d;
            mask_q     <= mask_d;
            ucnt_q     <= ucnt_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < RESP_W; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < RESP_W; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign busy          = (state_q != ST_IDLE);
    assign puf_start     = (state_q == ST_LAUNCH);
    assign puf_challenge = chal_q;
    assign resp_valid    = valid_q;
    assign response      = resp_q;
    assign unstable_mask = mask_q;
    assign unstable_cnt  = ucnt_q;
    assign err_timeout   = err_now;

endmodule

// File: tb/tb_puf_vote_seq.sv
// tb_puf_vote_seq
//  Scoreboard bench for puf_vote_seq with a small behavioural PUF core.
//  Expected results are queued when a request is issued and compared when
//  resp_valid (or err_timeout) appears, including the cycle it appears in.
module tb_puf_vote_seq;

    localparam int RESP_W  = 8;
    localparam int CHAL_W  = 8;
    localparam int VOTES   = 3;
    localparam int TMO_CYC = 16;
    localparam int L_DEF   = 4;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              start = 1'b0;
    logic [CHAL_W-1:0] challenge_in = '0;
    logic              puf_start;
    logic [CHAL_W-1:0] puf_challenge;
    logic              puf_done = 1'b0;
    logic [RESP_W-1:0] puf_response = '0;
    logic              busy;
    logic              resp_valid;
    logic [RESP_W-1:0] response;
    logic [RESP_W-1:0] unstable_mask;
    logic [3:0]        unstable_cnt;
    logic              err_timeout;

    puf_vote_seq #(
        .RESP_W (RESP_W),
        .CHAL_W (CHAL_W),
        .VOTES  (VOTES),
        .TMO_CYC(TMO_CYC)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .challenge_in (challenge_in),
        .puf_start    (puf_start),
        .puf_challenge(puf_challenge),
        .puf_done     (puf_done),
        .puf_response (puf_response),
        .busy         (busy),
        .resp_valid   (resp_valid),
        .response     (response),
        .unstable_mask(unstable_mask),
        .unstable_cnt (unstable_cnt),
        .err_timeout  (err_timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [RESP_W-1:0] resp;
        logic [RESP_W-1:0] mask;
        int                ucnt;
        int                at_cyc;
    } exp_t;

    exp_t              exp_q[$];
    int                tmo_q[$];
    logic [RESP_W-1:0] resp_fifo[$];

    int          lat = L_DEF;
    int          hold_cyc = 1;
    bit          silent = 1'b0;
    bit          stray = 1'b0;
    int          n_vec = 0;
    int          n_miss = 0;
    int          launches = 0;
    int          errs = 0;
    int          valids = 0;
    logic [7:0]  cur_chal = '0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Behavioural PUF core: answers each puf_start after 'lat' cycles with the
    // next queued response, holding puf_done for 'hold_cyc' cycles.
    initial begin
        int cd;
        int hold_left;
        cd = -1;
        hold_left = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!reset_n) begin
                cd = -1;
                hold_left = 0;
                puf_done = 1'b0;
            end else begin
                if (hold_left > 0) begin
                    hold_left--;
                    if (hold_left == 0) puf_done = 1'b0;
                end
                if (stray) begin
                    stray = 1'b0;
                    puf_done = 1'b1;
                    puf_response = 8'hFF;
                    hold_left = 1;
                end
                if (cd > 0) begin
                    cd--;
                    if (cd == 0) begin
                        puf_done = 1'b1;
                        puf_response = (resp_fifo.size() > 0) ? resp_fifo.pop_front() : '0;
                        hold_left = hold_cyc;
                        cd = -1;
                    end
                end
                if (puf_start && !silent) cd = lat;
            end
        end
    end

    // Output monitor / scoreboard consumer, sampled mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        int   t;
        if (reset_n) begin
            if (puf_start) begin
                launches++;
                check_val("puf_challenge", 32'(puf_challenge), 32'(cur_chal));
            end
            if (resp_valid) begin
                valids++;
                if (exp_q.size() == 0) begin
                    check_val("unexpected_valid", 32'(resp_valid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check_val("response", 32'(response), 32'(e.resp));
                    check_val("unstable_mask", 32'(unstable_mask), 32'(e.mask));
                    check_val("unstable_cnt", 32'(unstable_cnt), 32'(e.ucnt));
                    check_val("valid_cycle", 32'(cyc), 32'(e.at_cyc));
                    $display("txn: resp=0x%02h mask=0x%02h cnt=%0d at cycle %0d", response, unstable_mask, unstable_cnt, cyc);
                end
            end
            if (err_timeout) begin
                errs++;
                if (tmo_q.size() == 0) begin
                    check_val("unexpected_timeout", 32'(err_timeout), 32'd0);
                end else begin
                    t = tmo_q.pop_front();
                    check_val("timeout_cycle", 32'(cyc), 32'(t));
                    $display("txn: err_timeout at cycle %0d", cyc);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue a request from IDLE (called #1 after a clock edge) and queue its
    // three PUF responses plus the expected vote result.
    task automatic issue(input logic [7:0] chal, input logic [7:0] r0,
                         input logic [7:0] r1, input logic [7:0] r2);
        exp_t e;
        int   c;
        e.resp = '0;
        e.mask = '0;
        e.ucnt = 0;
        for (int i = 0; i < RESP_W; i++) begin
            c = int'(r0[i]) + int'(r1[i]) + int'(r2[i]);
            e.resp[i] = (c >= 2);
            if (c == 1 || c == 2) begin
                e.mask[i] = 1'b1;
                e.ucnt++;
            end
        end
        e.at_cyc = cyc + VOTES * (lat + 1) + 2;
        exp_q.push_back(e);
        resp_fifo.push_back(r0);
        resp_fifo.push_back(r1);
        resp_fifo.push_back(r2);
        cur_chal = chal;
        challenge_in = chal;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int bound);
        int k;
        k = 0;
        while ((busy || exp_q.size() != 0) && k < bound) begin
            tick();
            k++;
        end
        check_val("pending_results", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic wait_launches(input int base, input int n);
        int k;
        k = 0;
        while ((launches - base) < n && k < 100) begin
            tick();
            k++;
        end
        check_val("launch_reached", 32'(launches - base), 32'(n));
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_busy"}, 32'(busy), 32'd0);
        check_val({tag, "_puf_start"}, 32'(puf_start), 32'd0);
        check_val({tag, "_puf_chal"}, 32'(puf_challenge), 32'd0);
        check_val({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
        check_val({tag, "_response"}, 32'(response), 32'd0);
        check_val({tag, "_mask"}, 32'(unstable_mask), 32'd0);
        check_val({tag, "_ucnt"}, 32'(unstable_cnt), 32'd0);
        check_val({tag, "_err"}, 32'(err_timeout), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int lc;
        int e0;
        int v0;
        int k;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset_n = 1'b1;
        tick();

        // 1. Stable PUF
        lc = launches;
        issue(8'h3C, 8'hA5, 8'hA5, 8'hA5);
        wait_done(200);
        check_val("t1_launches", 32'(launches - lc), 32'd3);
        check_val("t1_response", 32'(response), 32'hA5);
        check_val("t1_mask", 32'(unstable_mask), 32'h00);
        check_val("t1_ucnt", 32'(unstable_cnt), 32'd0);
        check_val("t1_puf_chal", 32'(puf_challenge), 32'h3C);

        // 2. Noisy PUF
        issue(8'h11, 8'hF0, 8'hF1, 8'h70);
        wait_done(200);
        check_val("t2_response", 32'(response), 32'hF0);
        check_val("t2_mask", 32'(unstable_mask), 32'h81);
        check_val("t2_ucnt", 32'(unstable_cnt), 32'd2);

        // 3. Silent PUF -> timeout, previous results kept
        silent = 1'b1;
        e0 = errs;
        v0 = valids;
        cur_chal = 8'h55;
        challenge_in = 8'h55;
        tmo_q.push_back(cyc + 1 + TMO_CYC);
        start = 1'b1;
        tick();
        start = 1'b0;
        k = 0;
        while (tmo_q.size() != 0 && k < 100) begin
            tick();
            k++;
        end
        check_val("t3_timeout_seen", 32'(tmo_q.size()), 32'd0);
        tick();
        silent = 1'b0;
        check_val("t3_busy", 32'(busy), 32'd0);
        check_val("t3_err_count", 32'(errs - e0), 32'd1);
        check_val("t3_no_valid", 32'(valids - v0), 32'd0);
        check_val("t3_response_kept", 32'(response), 32'hF0);
        check_val("t3_mask_kept", 32'(unstable_mask), 32'h81);

        // Stray puf_done while IDLE must not leak into the next request
        stray = 1'b1;
        tick();
        tick();
        tick();
        issue(8'h5A, 8'h00, 8'h00, 8'h01);
        wait_done(200);

        // 4a. start while busy is ignored
        lc = launches;
        issue(8'h42, 8'h12, 8'h34, 8'h56);
        wait_launches(lc, 2);
        challenge_in = 8'h99;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(200);
        check_val("t4_launches", 32'(launches - lc), 32'd3);
        check_val("t4_puf_chal", 32'(puf_challenge), 32'h42);

        // 4b. asynchronous reset in the middle of run 2
        lc = launches;
        issue(8'h77, 8'hFF, 8'h00, 8'hFF);
        wait_launches(lc, 2);
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        check_all_zero("midrun_reset");
        exp_q.delete();
        resp_fifo.delete();
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        issue(8'h3C, 8'h0F, 8'h1F, 8'h0E);
        wait_done(200);
        check_val("t4_after_reset", 32'(response), 32'h0F);

        // 5. Back-to-back: start in the resp_valid cycle
        issue(8'h21, 8'hFF, 8'h00, 8'hFF);
        k = 0;
        while (!resp_valid && k < 200) begin
            tick();
            k++;
        end
        check_val("t5_first_valid", 32'(resp_valid), 32'd1);
        issue(8'h22, 8'h0F, 8'h0F, 8'h0F);
        wait_done(200);
        check_val("t5_response", 32'(response), 32'h0F);
        check_val("t5_mask", 32'(unstable_mask), 32'h00);

        // 6a. puf_done held for 3 cycles counts once per launch
        e0 = errs;
        lc = launches;
        hold_cyc = 3;
        issue(8'h66, 8'hC3, 8'h3C, 8'hC3);
        wait_done(200);
        hold_cyc = 1;
        check_val("t6_held_launches", 32'(launches - lc), 32'd3);
        check_val("t6_held_response", 32'(response), 32'hC3);

        // 6b. puf_done exactly on the last timer cycle wins over timeout
        lat = 16;
        issue(8'h67, 8'h01, 8'h03, 8'h07);
        wait_done(300);
        lat = L_DEF;
        check_val("t6_late_response", 32'(response), 32'h03);
        check_val("t6_late_ucnt", 32'(unstable_cnt), 32'd2);
        check_val("t6_no_timeout", 32'(errs - e0), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
